lb_pwm_timer: RTL and testbench

- Multi-channel PWM/update-timer peripheral; slave on the XT_LB low-speed bus. Occupies one lb_data_in slot.
- Drives a PWM vector that the AF GPIO block can route to pads as function outputs.
- Raises one level interrupt into the external interrupt controller on each counter update event.
- Runs on the bus clock, with a prescaler, preloaded period/duty and W1C status.

---
 rtl/lb_pwm_pkg.sv | 22 ++
 rtl/pwm_prescaler.sv | 20 ++
 rtl/lb_pwm_timer.sv | 119 +++++++++++
 tb/tb_lb_pwm_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lb_pwm_pkg.sv
// lb_pwm_pkg: register map, CTRL bit positions and CTRL layout for lb_pwm_timer
package lb_pwm_pkg;
   localparam logic [7:0] CTRL_OFS   = 8'd0;
   localparam logic [7:0] PSC_OFS    = 8'd1;
   localparam logic [7:0] PER_OFS    = 8'd2;
   localparam logic [7:0] STATUS_OFS = 8'd3;
   localparam logic [7:0] CNT_OFS    = 8'd4;
   localparam logic [7:0] DUTY_OFS   = 8'd5;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_ONE_SHOT = 2;
   localparam int CTRL_POL      = 4;

   typedef struct packed {
      logic [3:0] pol;
      logic       rsvd;
      logic       one_shot;
      logic       irq_en;
      logic       en;
   } ctrl_t;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the bus clock into counter ticks, one every PSC+1 enabled cycles
module pwm_prescaler #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic [CNT_WIDTH-1:0] psc_i,
   output logic                 tick_o
);
   logic [CNT_WIDTH-1:0] psc_cnt_q, psc_cnt_d;

   assign tick_o    = en_i && psc_cnt_q == psc_i;
   assign psc_cnt_d = (!en_i || tick_o) ? '0 : psc_cnt_q + CNT_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) psc_cnt_q <= '0;
      else psc_cnt_q <= psc_cnt_d;
   end
endmodule

// File: rtl/lb_pwm_timer.sv
// lb_pwm_timer: LB-bus PWM/update timer with prescaler, preloaded period/duty and W1C update flag
module lb_pwm_timer
   import lb_pwm_pkg::*;
#(
   parameter int         CH_NUM    = 4,
   parameter int         CNT_WIDTH = 16,
   parameter logic [7:0] BASE_ADDR = 8'd40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lb_read,
   input  logic              lb_write,
   input  logic [7:0]        lb_addr,
   input  logic [31:0]       lb_wdata,
   output logic [31:0]       rdata,
   output logic [CH_NUM-1:0] pwm_out,
   output logic              irq
);
   localparam logic [7:0] CTRL_WMASK = 8'((1 << CTRL_EN) | (1 << CTRL_IRQ_EN) | (1 << CTRL_ONE_SHOT) |
                                          (((1 << CH_NUM) - 1) << CTRL_POL));

   logic [7:0]           ofs;
   ctrl_t                ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0] psc_q, psc_d, per_q, per_d, cnt_q, cnt_d, per_act_q, per_act_d;
   logic [CNT_WIDTH-1:0] duty_q [CH_NUM];
   logic [CNT_WIDTH-1:0] duty_d [CH_NUM];
   logic [CNT_WIDTH-1:0] duty_act_q [CH_NUM];
   logic [CNT_WIDTH-1:0] duty_act_d [CH_NUM];
   logic                 uif_q, uif_d, irq_q, irq_d, tick, upd, w1c;
   logic [CH_NUM-1:0]    pwm_q, pwm_d;
   logic [31:0]          rd_val, rdata_q, rdata_d;
   logic                 unused_wdata;

   assign ofs          = lb_addr - BASE_ADDR;
   assign unused_wdata = ^lb_wdata;

   pwm_prescaler #(.CNT_WIDTH(CNT_WIDTH)) u_psc (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (ctrl_q.en),
      .psc_i  (psc_q),
      .tick_o (tick)
   );

   // while disabled the active period/duty shadow the preloads so enabling starts fresh
   assign upd       = tick && cnt_q == per_act_q;
   assign cnt_d     = !ctrl_q.en ? '0 : !tick ? cnt_q : upd ? '0 : cnt_q + CNT_WIDTH'(1);
   assign per_act_d = (!ctrl_q.en || upd) ? per_q : per_act_q;
   assign w1c       = lb_write && ofs == STATUS_OFS && lb_wdata[0];
   assign uif_d     = upd || (uif_q && !w1c);
   assign irq_d     = uif_q && ctrl_q.irq_en;
   assign rdata_d   = lb_read ? rd_val : '0;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      assign duty_act_d[c] = (!ctrl_q.en || upd) ? duty_q[c] : duty_act_q[c];
      assign pwm_d[c]      = (ctrl_q.en && cnt_q < duty_act_q[c]) ^ ctrl_q.pol[c];
   end

   always_comb begin
      ctrl_d = ctrl_q;
      psc_d  = psc_q;
      per_d  = per_q;
      duty_d = duty_q;
      if (lb_write) begin
         if (ofs == CTRL_OFS) ctrl_d = ctrl_t'(lb_wdata[7:0] & CTRL_WMASK);
         if (ofs == PSC_OFS) psc_d = lb_wdata[CNT_WIDTH-1:0];
         if (ofs == PER_OFS) per_d = lb_wdata[CNT_WIDTH-1:0];
         for (int i = 0; i < CH_NUM; i++)
            if (ofs == DUTY_OFS + 8'(i)) duty_d[i] = lb_wdata[CNT_WIDTH-1:0];
      end
      if (upd && ctrl_q.one_shot) ctrl_d.en = 1'b0;
   end

   always_comb begin
      rd_val = '0;
      case (ofs)
         CTRL_OFS:   rd_val = 32'(ctrl_q);
         PSC_OFS:    rd_val = 32'(psc_q);
         PER_OFS:    rd_val = 32'(per_q);
         STATUS_OFS: rd_val = {31'b0, uif_q};
         CNT_OFS:    rd_val = 32'(cnt_q);
         default:    ;
      endcase
      for (int i = 0; i < CH_NUM; i++)
         if (ofs == DUTY_OFS + 8'(i)) rd_val = 32'(duty_q[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         psc_q      <= '0;
         per_q      <= '0;
         cnt_q      <= '0;
         per_act_q  <= '0;
         duty_q     <= '{default: '0};
         duty_act_q <= '{default: '0};
         uif_q      <= 1'b0;
         irq_q      <= 1'b0;
         pwm_q      <= '0;
         rdata_q    <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         psc_q      <= psc_d;
         per_q      <= per_d;
         cnt_q      <= cnt_d;
         per_act_q  <= per_act_d;
         duty_q     <= duty_d;
         duty_act_q <= duty_act_d;
         uif_q      <= uif_d;
         irq_q      <= irq_d;
         pwm_q      <= pwm_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rdata   = rdata_q;
   assign pwm_out = pwm_q;
   assign irq     = irq_q;
endmodule

// File: tb/tb_lb_pwm_timer.sv
// tb_lb_pwm_timer: directed and random bus traffic checked against a register-level timer model
module tb_lb_pwm_timer;
   logic        clk = 0, rst_n = 0, lb_read = 0, lb_write = 0;
   logic [7:0]  lb_addr = '0;
   logic [31:0] lb_wdata = '0, rdata;
   logic [3:0]  pwm_out;
   logic        irq;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   lb_pwm_timer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .lb_read  (lb_read),
      .lb_write (lb_write),
      .lb_addr  (lb_addr),
      .lb_wdata (lb_wdata),
      .rdata    (rdata),
      .pwm_out  (pwm_out),
      .irq      (irq)
   );

   // reference state: programmed registers, live timer state, and predicted outputs
   bit          m_en, m_ie, m_os, m_uif, m_irq;
   logic [3:0]  m_pol, m_pwm;
   logic [15:0] m_psc, m_per, m_cnt, m_pcnt, m_per_act;
   logic [15:0] m_duty [4];
   logic [15:0] m_da [4];
   logic [31:0] m_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
   endtask

   function automatic logic [31:0] reg_val(input int o);
      case (o)
         0: return {24'b0, m_pol, 1'b0, m_os, m_ie, m_en};
         1: return {16'b0, m_psc};
         2: return {16'b0, m_per};
         3: return {31'b0, m_uif};
         4: return {16'b0, m_cnt};
         5, 6, 7, 8: return {16'b0, m_duty[o-5]};
         default: return 32'b0;
      endcase
   endfunction

   function automatic bit next_upd();
      return m_en && m_pcnt == m_psc && m_cnt == m_per_act;
   endfunction

   task automatic model_edge(input bit rd, input bit wr, input int o, input logic [31:0] d);
      bit tick, upd, os_old;
      tick   = m_en && m_pcnt == m_psc;
      upd    = tick && m_cnt == m_per_act;
      os_old = m_os;
      for (int i = 0; i < 4; i++) m_pwm[i] = (m_en && m_cnt < m_da[i]) ^ m_pol[i];
      m_rdata = rd ? reg_val(o) : 32'b0;
      m_irq   = m_uif && m_ie;
      if (!m_en) begin
         m_pcnt = 0; m_cnt = 0; m_per_act = m_per; m_da = m_duty;
      end else if (tick) begin
         m_pcnt = 0;
         if (upd) begin
            m_cnt = 0; m_per_act = m_per; m_da = m_duty;
         end else m_cnt = m_cnt + 16'd1;
      end else m_pcnt = m_pcnt + 16'd1;
      m_uif = upd || (m_uif && !(wr && o == 3 && d[0]));
      if (wr)
         case (o)
            0: begin m_pol = d[7:4]; m_os = d[2]; m_ie = d[1]; m_en = d[0]; end
            1: m_psc = d[15:0];
            2: m_per = d[15:0];
            5, 6, 7, 8: m_duty[o-5] = d[15:0];
            default: ;
         endcase
      if (upd && os_old) m_en = 0;
   endtask

   task automatic cyc(input bit rd, input bit wr, input int o, input logic [31:0] d);
      lb_read = rd; lb_write = wr; lb_addr = 8'(40 + o); lb_wdata = d;
      @(posedge clk);
      model_edge(rd, wr, o, d);
      #1 lb_read = 0; lb_write = 0;
      chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("rdata", rdata, m_rdata);
   endtask

   task automatic wr(input int o, input logic [31:0] d); cyc(0, 1, o, d); endtask
   task automatic rd(input int o); cyc(1, 0, o, 32'b0); endtask
   task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'b0); endtask

   initial begin
      int n, h0, h1, h2, h3, r, o;
      logic [31:0] d;
      m_en = 0; m_ie = 0; m_os = 0; m_uif = 0; m_irq = 0; m_pol = 0; m_pwm = 0;
      m_psc = 0; m_per = 0; m_cnt = 0; m_pcnt = 0; m_per_act = 0; m_rdata = 0;
      m_duty = '{default: '0}; m_da = '{default: '0};
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_rdata", rdata, 0);
      for (int k = -1; k <= 10; k++) begin
         rd(k);
         chk("rst_read", rdata, 0);
      end

      wr(2, 9); wr(5, 3); wr(0, 1);
      idle(9);
      rd(3); chk("uif_before_upd", rdata, 0);
      rd(3); chk("uif_after_10", rdata, 1);
      h0 = 0;
      for (int k = 0; k < 20; k++) begin idle(1); h0 += int'(pwm_out[0]); end
      chk("duty3_per10_highs", h0, 6);

      wr(2, 4); wr(5, 2);
      idle(20);
      h0 = 0;
      for (int k = 0; k < 10; k++) begin idle(1); h0 += int'(pwm_out[0]); end
      chk("duty2_per5_highs", h0, 4);

      wr(0, 3);
      n = 0;
      while (!next_upd() && n < 30) begin idle(1); n++; end
      chk("upd_within_bound", 32'(n < 30), 1);
      wr(3, 1);
      rd(3);
      chk("uif_set_wins", rdata, 1);
      chk("irq_kept", 32'(irq), 1);
      n = 0;
      while (next_upd() && n < 30) begin idle(1); n++; end
      wr(3, 1);
      chk("irq_lag", 32'(irq), 1);
      idle(1);
      chk("irq_dropped", 32'(irq), 0);

      wr(0, 0); wr(3, 1); wr(1, 2); wr(2, 3); wr(0, 32'h15);
      idle(12);
      rd(0); chk("oneshot_ctrl", rdata, 32'h14);
      rd(4); chk("oneshot_cnt", rdata, 0);
      chk("oneshot_pol", 32'(pwm_out), 32'h1);

      wr(0, 32'h80);
      idle(1);
      chk("pol3_idle", 32'(pwm_out), 32'h8);
      wr(1, 0); wr(2, 9); wr(6, 0); wr(7, 16'hFFFF); wr(8, 0); wr(0, 32'h81);
      h1 = 0; h2 = 0; h3 = 0;
      for (int k = 0; k < 25; k++) begin
         idle(1);
         h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]); h3 += int'(pwm_out[3]);
      end
      chk("duty0_never_high", h1, 0);
      chk("duty_gt_per_always", h2, 25);
      chk("pol3_duty0_always", h3, 25);

      for (int k = 0; k < 1500; k++) begin
         r = int'($urandom_range(0, 9));
         d = $urandom;
         if (r < 5) idle(1);
         else if (r < 7) begin
            o = int'($urandom_range(0, 11)) - 1;
            rd(o);
         end else begin
            o = int'($urandom_range(0, 10));
            case (o)
               0: if (next_upd() && m_os) idle(1); else wr(0, d);
               1: if (m_en) idle(1); else wr(1, {d[31:16], 16'($urandom_range(0, 3))});
               2: wr(2, {d[31:16], 16'($urandom_range(0, 12))});
               5, 6, 7, 8: wr(o, {d[31:16], ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 14))});
               default: wr(o, d);
            endcase
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
